// File: rtl/clock_monitor.sv
`default_nettype none
// ----------------------------------------------------------------------------
// clock_monitor: synchronises a slow monitored clock, emits rise/fall pulses,
// measures phase lengths and flags fast or stalled clocks.
// Optional feature macro: CLKMON_STICKY_EN (adds fault_clr / fault_sticky).
// Rev 1.0
// ----------------------------------------------------------------------------
module clock_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16,
  parameter int MIN_HALF    = 4,
  parameter int MAX_HALF    = 1000,
  parameter int LOCK_CNT    = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             mon_in,
  input  logic             enable,
`ifdef CLKMON_STICKY_EN
  input  logic             fault_clr,
  output logic             fault_sticky,
`endif
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] half_period,
  output logic             period_valid,
  output logic             locked,
  output logic             too_fast,
  output logic             stuck
);

  localparam int GOOD_W = $clog2(LOCK_CNT + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ACQUIRE = 3'd1;
  localparam logic [2:0] S_MEASURE = 3'd2;
  localparam logic [2:0] S_LOCKED  = 3'd3;
  localparam logic [2:0] S_FAULT   = 3'd4;

  localparam logic [CNT_W-1:0]  MIN_V    = CNT_W'(MIN_HALF);
  localparam logic [CNT_W-1:0]  MAX_V    = CNT_W'(MAX_HALF);
  localparam logic [CNT_W-1:0]  CNT_SAT  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [GOOD_W-1:0] LOCK_VAL = GOOD_W'(LOCK_CNT);
  localparam logic [GOOD_W-1:0] GOOD_ONE = GOOD_W'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   rise_q;
  logic                   fall_q;
  logic [CNT_W-1:0]       cnt_q,   cnt_d;
  logic [CNT_W-1:0]       half_q,  half_d;
  logic                   pv_q,    pv_d;
  logic [GOOD_W-1:0]      good_q,  good_d;
  logic [2:0]             state_q, state_d;
  logic                   locked_q;
  logic                   tf_q,    tf_d;
  logic                   st_q,    st_d;

  logic                   sync_s;
  logic                   edge_w;
  logic [GOOD_W-1:0]      good_inc;
  logic [CNT_W-1:0]       cnt_inc;

  assign sync_s   = sync_q[SYNC_STAGES-1];
  assign edge_w   = sync_s ^ prev_q;
  assign good_inc = good_q + GOOD_ONE;
  assign cnt_inc  = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_ONE;

  // Synchroniser and edge pulses run regardless of FSM state.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], mon_in};
      prev_q <= sync_s;
      rise_q <= sync_s & ~prev_q;
      fall_q <= ~sync_s & prev_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    half_d  = half_q;
    pv_d    = 1'b0;
    good_d  = good_q;
    tf_d    = tf_q;
    st_d    = st_q;
    if (!enable) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      half_d  = '0;
      good_d  = '0;
      tf_d    = 1'b0;
      st_d    = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_ACQUIRE;
          cnt_d   = '0;
        end
        S_ACQUIRE: begin
          // First edge only anchors the counter; its phase length is unknown.
          if (edge_w) begin
            cnt_d   = CNT_ONE;
            good_d  = '0;
            state_d = S_MEASURE;
          end
        end
        S_MEASURE, S_LOCKED, S_FAULT: begin
          cnt_d = edge_w ? CNT_ONE : cnt_inc;
          if (edge_w) begin
            half_d = cnt_q;
            pv_d   = 1'b1;
            if (cnt_q < MIN_V) begin
              state_d = S_FAULT;
              tf_d    = 1'b1;
              st_d    = 1'b0;
            end else if (cnt_q > MAX_V) begin
              state_d = S_FAULT;
              tf_d    = 1'b0;
              st_d    = 1'b1;
            end else if (state_q == S_FAULT) begin
              state_d = S_MEASURE;
              good_d  = GOOD_ONE;
              tf_d    = 1'b0;
              st_d    = 1'b0;
            end else if (state_q == S_MEASURE) begin
              good_d = good_inc;
              if (good_inc >= LOCK_VAL) begin
                state_d = S_LOCKED;
              end
            end
          end else if (cnt_q > MAX_V) begin
            state_d = S_FAULT;
            tf_d    = 1'b0;
            st_d    = 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      half_q   <= '0;
      pv_q     <= 1'b0;
      good_q   <= '0;
      locked_q <= 1'b0;
      tf_q     <= 1'b0;
      st_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      half_q   <= half_d;
      pv_q     <= pv_d;
      good_q   <= good_d;
      // Derived from the next state so locked drops on the entry cycle.
      locked_q <= (state_d == S_LOCKED);
      tf_q     <= tf_d;
      st_q     <= st_d;
    end
  end

`ifdef CLKMON_STICKY_EN
  logic sticky_q;

  // A new fault entry takes priority over a simultaneous clear.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sticky_q <= 1'b0;
    end else if ((state_d == S_FAULT) && (state_q != S_FAULT)) begin
      sticky_q <= 1'b1;
    end else if (fault_clr) begin
      sticky_q <= 1'b0;
    end
  end

  assign fault_sticky = sticky_q;
`endif

  assign rise         = rise_q;
  assign fall         = fall_q;
  assign half_period  = half_q;
  assign period_valid = pv_q;
  assign locked       = locked_q;
  assign too_fast     = tf_q;
  assign stuck        = st_q;

endmodule
`default_nettype wire

// File: tb/tb_clock_monitor.sv
`default_nettype none
// tb_clock_monitor: directed self-checking bench for clock_monitor.
module tb_clock_monitor;

  logic        CLK;
  logic        RST;
  logic        mon_in;
  logic        enable;
  logic        rise;
  logic        fall;
  logic [15:0] half_period;
  logic        period_valid;
  logic        locked;
  logic        too_fast;
  logic        stuck;
`ifdef CLKMON_STICKY_EN
  logic        fault_clr;
  logic        fault_sticky;
`endif

  clock_monitor #(
    .SYNC_STAGES(2),
    .CNT_W      (16),
    .MIN_HALF   (4),
    .MAX_HALF   (1000),
    .LOCK_CNT   (4)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .mon_in      (mon_in),
    .enable      (enable),
`ifdef CLKMON_STICKY_EN
    .fault_clr   (fault_clr),
    .fault_sticky(fault_sticky),
`endif
    .rise        (rise),
    .fall        (fall),
    .half_period (half_period),
    .period_valid(period_valid),
    .locked      (locked),
    .too_fast    (too_fast),
    .stuck       (stuck)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks;
  int failures;

  // Observations gathered at every sampling negedge.
  int pv_cnt;
  int last_hp;
  int last_lk;
  int last_tf;
  int since;
  int rise_run, rise_w;
  int fall_run, fall_w;
  int lock_seen, lock_at;
  int stuck_seen, stuck_at;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    pv_cnt = 0; last_hp = -1; last_lk = -1; last_tf = -1; since = 0;
    rise_run = 0; rise_w = 0; fall_run = 0; fall_w = 0;
    lock_seen = 0; lock_at = -1; stuck_seen = 0; stuck_at = -1;
  endtask

  task automatic step();
    @(negedge CLK);
    if (period_valid) begin
      pv_cnt++;
      last_hp = int'(half_period);
      last_lk = int'(locked);
      last_tf = int'(too_fast);
      since   = 0;
    end else begin
      since++;
    end
    if (rise) rise_run++; else rise_run = 0;
    if (rise_run > rise_w) rise_w = rise_run;
    if (fall) fall_run++; else fall_run = 0;
    if (fall_run > fall_w) fall_w = fall_run;
    if (locked && lock_seen == 0) begin lock_seen = 1; lock_at = pv_cnt; end
    if (stuck && stuck_seen == 0) begin stuck_seen = 1; stuck_at = since; end
  endtask

  // Toggle mon_in, then hold it for n cycles.
  task automatic run_phase(input int n);
    mon_in = ~mon_in;
    repeat (n) step();
  endtask

  initial begin
    checks = 0; failures = 0;
    mon_in = 1'b0; enable = 1'b0;
`ifdef CLKMON_STICKY_EN
    fault_clr = 1'b0;
`endif
    RST = 1'b1;
    clear_stats();
    step(); step();
    chk("reset_rise",   32'(rise),         32'd0);
    chk("reset_fall",   32'(fall),         32'd0);
    chk("reset_hp",     32'(half_period),  32'd0);
    chk("reset_pv",     32'(period_valid), 32'd0);
    chk("reset_locked", 32'(locked),       32'd0);
    chk("reset_tf",     32'(too_fast),     32'd0);
    chk("reset_stuck",  32'(stuck),        32'd0);
`ifdef CLKMON_STICKY_EN
    chk("reset_sticky", 32'(fault_sticky), 32'd0);
`endif

    // Lock onto a 10-cycle phase
    RST = 1'b0; enable = 1'b1;
    step();
    clear_stats();
    run_phase(10);
    chk("acq_no_pv", 32'(pv_cnt), 32'd0);
    repeat (4) run_phase(10);
    chk("lock_pv_cnt",  32'(pv_cnt),  32'd4);
    chk("lock_hp",      32'(last_hp), 32'd10);
    chk("lock_at_4th",  32'(lock_at), 32'd4);
    chk("rise_width",   32'(rise_w),  32'd1);
    chk("fall_width",   32'(fall_w),  32'd1);
    chk("locked_lvl",   32'(locked),  32'd1);

    // Too-fast phase of 2 cycles, then recovery
    run_phase(2);
    run_phase(10);
    chk("fast_hp",      32'(last_hp),  32'd2);
    chk("fast_tf_edge", 32'(last_tf),  32'd1);
    chk("fast_lk_edge", 32'(last_lk),  32'd0);
    chk("fast_tf_lvl",  32'(too_fast), 32'd1);
    run_phase(10);
    chk("recov_tf",     32'(too_fast), 32'd0);
    chk("recov_hp",     32'(last_hp),  32'd10);
    chk("recov_unlock", 32'(locked),   32'd0);
    run_phase(10); run_phase(10);
    chk("relock_early", 32'(locked),   32'd0);
    run_phase(10);
    chk("relock",       32'(locked),   32'd1);

    // Phase of exactly MAX_HALF is legal
    clear_stats();
    run_phase(1000);
    run_phase(10);
    chk("max_hp",       32'(last_hp),    32'd1000);
    chk("max_no_stuck", 32'(stuck_seen), 32'd0);
    chk("max_locked",   32'(locked),     32'd1);

    // Stall: stuck 1001 cycles after the last edge
    clear_stats();
    run_phase(1100);
    chk("stuck_at",     32'(stuck_at), 32'd1001);
    chk("stuck_lvl",    32'(stuck),    32'd1);
    chk("stuck_unlock", 32'(locked),   32'd0);
    chk("stuck_tf",     32'(too_fast), 32'd0);
    repeat (5) run_phase(10);
    chk("stuck_recov",  32'(stuck),    32'd0);
    chk("stuck_relock", 32'(locked),   32'd1);
`ifdef CLKMON_STICKY_EN
    chk("sticky_hold",  32'(fault_sticky), 32'd1);
    fault_clr = 1'b1; step(); fault_clr = 1'b0;
    chk("sticky_clr1",  32'(fault_sticky), 32'd0);
`endif

    // Fast fault with fault_clr pulsed on the fault-entry cycle
    mon_in = ~mon_in; step(); step();
    mon_in = ~mon_in; step(); step();
`ifdef CLKMON_STICKY_EN
    fault_clr = 1'b1;
`endif
    step();
`ifdef CLKMON_STICKY_EN
    fault_clr = 1'b0;
    chk("sticky_set_wins", 32'(fault_sticky), 32'd1);
`endif
    chk("fault2_tf",  32'(too_fast), 32'd1);
    chk("fault2_lk",  32'(locked),   32'd0);
    repeat (5) run_phase(10);
    chk("relock2",    32'(locked),   32'd1);
`ifdef CLKMON_STICKY_EN
    chk("sticky_survive", 32'(fault_sticky), 32'd1);
    fault_clr = 1'b1; step(); fault_clr = 1'b0;
    chk("sticky_clr2",    32'(fault_sticky), 32'd0);
`endif

    // One-cycle disable clears state; first edge after re-enable has no pv
    enable = 1'b0;
    step();
    chk("dis_locked", 32'(locked),      32'd0);
    chk("dis_hp",     32'(half_period), 32'd0);
    chk("dis_tf",     32'(too_fast),    32'd0);
    chk("dis_stuck",  32'(stuck),       32'd0);
    enable = 1'b1;
    clear_stats();
    run_phase(10);
    chk("reen_no_pv", 32'(pv_cnt),  32'd0);
    run_phase(10);
    chk("reen_pv",    32'(pv_cnt),  32'd1);
    chk("reen_hp",    32'(last_hp), 32'd10);

    // Asynchronous reset between clock edges
    #2 RST = 1'b1;
    #1;
    chk("arst_hp",    32'(half_period),  32'd0);
    chk("arst_pv",    32'(period_valid), 32'd0);
    chk("arst_rise",  32'(rise),         32'd0);
    chk("arst_fall",  32'(fall),         32'd0);
    mon_in = 1'b1;
    step(); step();
    RST = 1'b0;
    step();
    chk("post_rst_rise1", 32'(rise), 32'd0);
    step();
    chk("post_rst_rise2", 32'(rise), 32'd0);
    step();
    chk("post_rst_rise3", 32'(rise),         32'd1);
    chk("post_rst_no_pv", 32'(period_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
